tick_frame_ctrl: RTL and testbench

//  Frame controller between the SPI byte receiver and the feature extraction engine.

---
 rtl/mm_tick_pkg.sv | 11 +
 rtl/tick_sat_cnt.sv | 14 +
 rtl/tick_frame_ctrl.sv | 128 ++++++++++++
 tb/tb_tick_frame_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_tick_pkg.sv
// mm_tick_pkg: shared states, error codes and field widths for the tick frame controller.
package mm_tick_pkg;
    typedef enum logic [2:0] {S_HUNT, S_TYPE, S_PH, S_PL, S_SZ, S_CHK, S_EMIT} state_t;
    localparam logic [1:0] ERR_BADTYPE = 2'd0;
    localparam logic [1:0] ERR_BADSUM  = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int PRICE_W = 16;
    localparam int SIZE_W  = 8;
endpackage

// File: rtl/tick_sat_cnt.sv
// tick_sat_cnt: saturating up-counter that sticks at all-ones.
module tick_sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);
    // Count up on inc, holding once every bit is set.
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (inc && !(&q)) q <= q + 1'b1;
endmodule

// File: rtl/tick_frame_ctrl.sv
// tick_frame_ctrl: hunts sync, assembles/checks tick frames, hands them over valid/ready.
// Define CHECKSUM_EN to add the trailing XOR check byte (6-byte frames instead of 5).
module tick_frame_ctrl
    import mm_tick_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF,
    parameter int         TIMEOUT_CYC = 4096,
    parameter int         CNT_W       = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic               frame_abort,
    output logic               upd_val,
    input  logic               upd_rdy,
    output logic               upd_side,
    output logic               upd_kind,
    output logic [PRICE_W-1:0] upd_price,
    output logic [SIZE_W-1:0]  upd_size,
    output logic               err_pulse,
    output logic [1:0]         err_code,
    output logic [CNT_W-1:0]   ok_cnt,
    output logic [CNT_W-1:0]   err_cnt
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    state_t        state;
    logic [TW-1:0] gap;
`ifdef CHECKSUM_EN
    logic [7:0]    xsum;
`endif
    logic          acc, in_frame, abort, bad_type, bad_sum, tmo, err;
    logic [1:0]    code;

    // Classify this cycle: byte accept plus every error source, resolved by priority.
    always_comb begin
        acc      = in_val && in_rdy;
        in_frame = state inside {S_TYPE, S_PH, S_PL, S_SZ, S_CHK};
        abort    = in_frame && frame_abort;
        bad_type = state == S_TYPE && acc && |in_data[7:2];
`ifdef CHECKSUM_EN
        bad_sum  = state == S_CHK && acc && in_data != xsum;
`else
        bad_sum  = 1'b0;
`endif
        tmo      = in_frame && !acc && gap == TW'(TIMEOUT_CYC - 1);
        err      = abort || bad_type || bad_sum || tmo;
        code     = abort ? ERR_ABORT : bad_type ? ERR_BADTYPE : bad_sum ? ERR_BADSUM : ERR_TIMEOUT;
    end

    // Frame FSM with field capture, running XOR, gap timer and registered handshake outputs.
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state     <= S_HUNT;
            gap       <= '0;
`ifdef CHECKSUM_EN
            xsum      <= '0;
`endif
            in_rdy    <= 1'b1;
            upd_val   <= 1'b0;
            upd_side  <= 1'b0;
            upd_kind  <= 1'b0;
            upd_price <= '0;
            upd_size  <= '0;
            err_pulse <= 1'b0;
            err_code  <= '0;
        end else begin
            err_pulse <= err;
            if (err) begin
                err_code <= code;
                state    <= S_HUNT;
                gap      <= '0;
            end else begin
                gap <= (acc || !in_frame) ? '0 : gap + 1'b1;
                case (state)
                    S_HUNT: if (acc && in_data == SYNC_BYTE) state <= S_TYPE;
                    S_TYPE: if (acc) begin
                        upd_side <= in_data[0];
                        upd_kind <= in_data[1];
`ifdef CHECKSUM_EN
                        xsum     <= in_data;
`endif
                        state    <= S_PH;
                    end
                    S_PH: if (acc) begin
                        upd_price[15:8] <= in_data;
`ifdef CHECKSUM_EN
                        xsum            <= xsum ^ in_data;
`endif
                        state           <= S_PL;
                    end
                    S_PL: if (acc) begin
                        upd_price[7:0] <= in_data;
`ifdef CHECKSUM_EN
                        xsum           <= xsum ^ in_data;
`endif
                        state          <= S_SZ;
                    end
                    S_SZ: if (acc) begin
                        upd_size <= in_data;
`ifdef CHECKSUM_EN
                        xsum     <= xsum ^ in_data;
                        state    <= S_CHK;
`else
                        state    <= S_EMIT;
                        upd_val  <= 1'b1;
                        in_rdy   <= 1'b0;
`endif
                    end
                    S_CHK: if (acc) begin
                        state   <= S_EMIT;
                        upd_val <= 1'b1;
                        in_rdy  <= 1'b0;
                    end
                    S_EMIT: if (upd_rdy) begin
                        state   <= S_HUNT;
                        upd_val <= 1'b0;
                        in_rdy  <= 1'b1;
                    end
                    default: state <= S_HUNT;
                endcase
            end
        end

    tick_sat_cnt #(.W(CNT_W)) u_ok  (.clk(clk), .rst(rst), .inc(upd_val && upd_rdy), .q(ok_cnt));
    tick_sat_cnt #(.W(CNT_W)) u_err (.clk(clk), .rst(rst), .inc(err), .q(err_cnt));
endmodule

// File: tb/tb_tick_frame_ctrl.sv
// tb_tick_frame_ctrl: randomized frame scenarios against a frame-level scoreboard model.
module tb_tick_frame_ctrl;
    localparam int T = 16;
`ifdef CHECKSUM_EN
    localparam int N = 6;
`else
    localparam int N = 5;
`endif
    logic        clk = 0, rst = 1;
    logic [7:0]  in_data = 0;
    logic        in_val = 0, frame_abort = 0, upd_rdy = 0;
    logic        in_rdy, upd_val, upd_side, upd_kind, err_pulse;
    logic [15:0] upd_price;
    logic [7:0]  upd_size, ok_cnt, err_cnt;
    logic [1:0]  err_code;

    tick_frame_ctrl #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYC(T), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_val(in_val), .in_rdy(in_rdy),
        .frame_abort(frame_abort), .upd_val(upd_val), .upd_rdy(upd_rdy),
        .upd_side(upd_side), .upd_kind(upd_kind), .upd_price(upd_price), .upd_size(upd_size),
        .err_pulse(err_pulse), .err_code(err_code), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        logic        side, kind;
        logic [15:0] price;
        logic [7:0]  size;
        int          cnt;
    } exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_bad = 0, ok_n = 0, err_n = 0;
    bit rdy_hold = 0, rdy_always = 0, fast = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic exp_upd(input logic [7:0] t, input logic [7:0] ph, input logic [7:0] pl, input logic [7:0] sz);
        exp_t e;
        e.is_err = 0; e.code = 0; e.side = t[0]; e.kind = t[1];
        e.price = {ph, pl}; e.size = sz; e.cnt = ok_n;
        sb.push_back(e);
        if (ok_n < 255) ok_n++;
    endtask

    task automatic exp_err(input logic [1:0] c);
        exp_t e;
        if (err_n < 255) err_n++;
        e.is_err = 1; e.code = c; e.side = 0; e.kind = 0; e.price = 0; e.size = 0; e.cnt = err_n;
        sb.push_back(e);
    endtask

    function automatic logic [5:0][7:0] build(input logic [7:0] t, input logic [7:0] ph, input logic [7:0] pl, input logic [7:0] sz);
        build = {t ^ ph ^ pl ^ sz, sz, pl, ph, t, 8'hA5};
    endfunction

    function automatic int gap_pick();
        int r;
        r = $urandom_range(0, 9);
        return fast ? 0 : r < 7 ? r % 3 : r < 9 ? T - 1 : T - 2;
    endfunction

    function automatic logic [7:0] rnd_byte();
        return ($urandom % 5 == 0) ? 8'hA5 : 8'($urandom);
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bit r;
        idle(gap);
        in_val = 1;
        in_data = b;
        for (int i = 0; ; i++) begin
            @(negedge clk);
            r = in_rdy;
            @(posedge clk);
            #1;
            if (r) break;
            if (i > 500) begin
                $display("FAIL in_rdy_wait: got in_rdy=0 for 500 cycles expected 1");
                $fatal(1);
            end
        end
        in_val = 0;
    endtask

    task automatic good(input logic [7:0] t, input logic [7:0] ph, input logic [7:0] pl, input logic [7:0] sz, input bit abort_emit);
        logic [5:0][7:0] f;
        f = build(t, ph, pl, sz);
        exp_upd(t, ph, pl, sz);
        for (int i = 0; i < N; i++) send(f[i], i == 0 ? 0 : gap_pick());
        if (abort_emit) begin
            frame_abort = 1;
            idle(1);
            frame_abort = 0;
        end
    endtask

    task automatic junk();
        logic [7:0] b;
        repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == 8'hA5) b = 8'h00;
            send(b, $urandom_range(0, 3));
        end
    endtask

    task automatic partial(output logic [5:0][7:0] f, input int k);
        f = build(8'($urandom_range(0, 3)), rnd_byte(), rnd_byte(), rnd_byte());
        for (int i = 0; i < k; i++) send(f[i], i == 0 ? 0 : gap_pick());
    endtask

    always @(negedge clk) if (!rst) begin
        chk("in_rdy_vs_emit", in_rdy, !upd_val);
        if (upd_val) begin
            if (sb.size() == 0 || sb[0].is_err) begin
                n_cmp++; n_bad++;
                $display("FAIL upd_unexpected: got upd_val=1 expected no update");
            end else begin
                chk("upd_side", upd_side, sb[0].side);
                chk("upd_kind", upd_kind, sb[0].kind);
                chk("upd_price", upd_price, sb[0].price);
                chk("upd_size", upd_size, sb[0].size);
                if (upd_rdy) begin
                    chk("ok_cnt", ok_cnt, sb[0].cnt);
                    void'(sb.pop_front());
                end
            end
        end
        if (err_pulse) begin
            if (sb.size() == 0 || !sb[0].is_err) begin
                n_cmp++; n_bad++;
                $display("FAIL err_unexpected: got err_pulse=1 code=%0d expected none", err_code);
            end else begin
                chk("err_code", err_code, sb[0].code);
                chk("err_cnt", err_cnt, sb[0].cnt);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            upd_rdy = rdy_hold ? 1'b0 : rdy_always ? 1'b1 : ($urandom % 3 != 0);
        end
    end

    initial begin
        logic [5:0][7:0] f;
        int k;
        #12;
        chk("rst_in_rdy", in_rdy, 1);
        chk("rst_upd_val", upd_val, 0);
        chk("rst_err_pulse", err_pulse, 0);
        chk("rst_err_code", err_code, 0);
        chk("rst_ok_cnt", ok_cnt, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_fields", {upd_side, upd_kind, upd_price, upd_size}, 0);
        @(posedge clk);
        #1;
        rst = 0;
`ifdef CHECKSUM_EN
        good(8'h01, 8'h12, 8'h34, 8'h0A, 0);
        exp_err(2'd1);
        f = {8'h2C, 8'h0A, 8'h34, 8'h12, 8'h01, 8'hA5};
        for (int i = 0; i < N; i++) send(f[i], 0);
        good(8'h01, 8'h12, 8'h34, 8'h0A, 0);
`else
        good(8'h03, 8'h00, 8'h10, 8'hFF, 0);
`endif
        send(8'h00, 0);
        send(8'hFF, 0);
        exp_err(2'd0);
        send(8'hA5, 0);
        send(8'h04, 0);
        rdy_hold = 1;
        good(8'h02, 8'hA5, 8'h5A, 8'h77, 1);
        idle(20);
        rdy_hold = 0;
        for (int s = 0; s < 150; s++) begin
            junk();
            case ($urandom_range(0, 6))
                3: begin
                    exp_err(2'd0);
                    send(8'hA5, 0);
                    send({6'($urandom_range(1, 63)), 2'($urandom)}, gap_pick());
                end
                4: begin
                    exp_err(2'd2);
                    partial(f, $urandom_range(1, N - 1));
                    idle(T);
                end
                5: begin
                    exp_err(2'd3);
                    partial(f, $urandom_range(1, N - 1));
                    idle($urandom_range(0, 2));
                    frame_abort = 1;
                    in_val = 1'($urandom);
                    in_data = rnd_byte();
                    idle(1);
                    frame_abort = 0;
                    in_val = 0;
                end
`ifdef CHECKSUM_EN
                6: begin
                    exp_err(2'd1);
                    f = build(8'($urandom_range(0, 3)), rnd_byte(), rnd_byte(), rnd_byte());
                    f[5] = f[5] ^ 8'($urandom_range(1, 255));
                    for (int i = 0; i < N; i++) send(f[i], i == 0 ? 0 : gap_pick());
                end
`endif
                default: good(8'($urandom_range(0, 3)), rnd_byte(), rnd_byte(), rnd_byte(), $urandom % 4 == 0);
            endcase
        end
        rdy_always = 1;
        fast = 1;
        for (int s = 0; s < 300; s++) good(8'($urandom_range(0, 3)), rnd_byte(), rnd_byte(), rnd_byte(), 0);
        for (int i = 0; i < 200 && sb.size() > 0; i++) idle(1);
        chk("scoreboard_drained", sb.size(), 0);
        idle(2);
        chk("final_ok_cnt", ok_cnt, ok_n);
        chk("final_err_cnt", err_cnt, err_n);
        chk("final_ok_sat", ok_cnt, 255);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
